// File: rtl/noc_credit_rx_buffer_if.sv
// noc_credit_rx_buffer_if
//   Handshake bundle for one receive-side NoC channel buffer.
//   Incoming side : in_valid/in_data (no backpressure), in_yummy credit return.
//   Outgoing side : out_valid/out_data/out_sop/out_eop with out_ready.
//   Modports:
//     slave  - the buffer itself (consumes in_*, produces out_* and in_yummy)
//     master - the surrounding logic (drives in_*, out_ready; observes the rest)
interface noc_credit_rx_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_yummy;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_yummy, out_valid, out_data, out_sop, out_eop
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_yummy, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/noc_credit_rx_buffer.sv
// noc_credit_rx_buffer
//   Receive-side buffer for one OpenPiton NoC channel. Flits arriving under
//   the valid/yummy credit protocol are stored in a DEPTH-entry FIFO; one
//   yummy is returned (registered) per flit consumed downstream. The head
//   flit is presented on a valid/ready interface with sop/eop markers derived
//   from the header payload-length field.
//   Ports:
//     clock     - sole clock, all state updates on posedge
//     rst_n     - asynchronous active-low reset
//     bus       - handshake bundle (slave view): in_valid, in_data, in_yummy,
//                 out_valid, out_data, out_sop, out_eop, out_ready
//     overflow  - sticky: a flit arrived while full with no pop
//     level     - current occupancy, 0..DEPTH
module noc_credit_rx_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int LEN_LSB    = 22,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     rst_n,
    noc_credit_rx_buffer_if.slave    bus,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    typedef enum logic {
        HDR,
        BODY
    } frame_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    frame_state_t          state;
    logic [LEN_WIDTH-1:0]  rem;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  full;
    logic                  push;
    logic                  pop;

    always_comb begin
        full     = (level == FULL_LEVEL);
        pop      = bus.out_valid & bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = bus.in_valid & (~full | pop);
        head_len = bus.out_data[LEN_LSB +: LEN_WIDTH];
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_sop   = (state == HDR);
    // Gated by out_valid so eop reads 0 while empty (stale RAM contents).
    assign bus.out_eop   = bus.out_valid &
                           ((state == HDR) ? (head_len == '0)
                                           : (rem == LEN_WIDTH'(1)));

    // Storage carries no reset: contents are only observable when level != 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            bus.in_yummy <= 1'b0;
            overflow     <= 1'b0;
            state        <= HDR;
            rem          <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            bus.in_yummy <= pop;

            if (bus.in_valid && full && !pop) begin
                overflow <= 1'b1;
            end

            // Framing advances on consumption only.
            if (pop) begin
                case (state)
                    HDR: begin
                        if (head_len != '0) begin
                            rem   <= head_len;
                            state <= BODY;
                        end
                    end
                    BODY: begin
                        rem <= rem - LEN_WIDTH'(1);
                        if (rem == LEN_WIDTH'(1)) begin
                            state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_noc_credit_rx_buffer.sv
// tb_noc_credit_rx_buffer
//   Directed bench for noc_credit_rx_buffer (DATA_WIDTH=64, DEPTH=4,
//   LEN_LSB=22, LEN_WIDTH=8). Inputs change 1 time unit after posedge,
//   outputs are sampled at the same point.
module tb_noc_credit_rx_buffer;
    logic       clock;
    logic       rst_n;
    logic       overflow;
    logic [2:0] level;
    int unsigned total;
    int unsigned passed;
    int unsigned fails;

    noc_credit_rx_buffer_if #(.DATA_WIDTH(64)) bus ();

    noc_credit_rx_buffer #(
        .DATA_WIDTH(64),
        .DEPTH     (4),
        .LEN_LSB   (22),
        .LEN_WIDTH (8)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .overflow(overflow),
        .level   (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Header flit: len in [29:22], tag in low bits, marker in the top bits.
    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [15:0] tag);
        return 64'hA5A5_0000_0000_0000 | (64'(len) << 22) | 64'(tag);
    endfunction

    // Body flit: length-field bits all ones, which must not affect framing.
    function automatic logic [63:0] body(input logic [15:0] tag);
        return 64'hB0D1_0000_3FC0_0000 | 64'(tag);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_yummy", 64'(bus.in_yummy), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sop",   64'(bus.out_sop), 64'd1);
        chk("rst_eop",   64'(bus.out_eop), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        #6 rst_n = 1'b1;
        tick();

        // 1: single len=0 header
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = hdr(8'd0, 16'h00A1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data",  bus.out_data, hdr(8'd0, 16'h00A1));
        chk("t1_sop",   64'(bus.out_sop), 64'd1);
        chk("t1_eop",   64'(bus.out_eop), 64'd1);
        chk("t1_yummy0", 64'(bus.in_yummy), 64'd0);
        tick();
        chk("t1_yummy1", 64'(bus.in_yummy), 64'd1);
        chk("t1_empty",  64'(bus.out_valid), 64'd0);
        chk("t1_level",  64'(level), 64'd0);
        tick();
        chk("t1_yummy2", 64'(bus.in_yummy), 64'd0);

        // 2: header len=3 plus three body flits, streaming
        bus.in_valid = 1'b1;
        bus.in_data  = hdr(8'd3, 16'h0200);
        tick();
        bus.in_data = body(16'h0201);
        chk("t2_h_data", bus.out_data, hdr(8'd3, 16'h0200));
        chk("t2_h_sop",  64'(bus.out_sop), 64'd1);
        chk("t2_h_eop",  64'(bus.out_eop), 64'd0);
        chk("t2_h_yum",  64'(bus.in_yummy), 64'd0);
        tick();
        bus.in_data = body(16'h0202);
        chk("t2_b1_data", bus.out_data, body(16'h0201));
        chk("t2_b1_sop",  64'(bus.out_sop), 64'd0);
        chk("t2_b1_eop",  64'(bus.out_eop), 64'd0);
        chk("t2_b1_yum",  64'(bus.in_yummy), 64'd1);
        tick();
        bus.in_data = body(16'h0203);
        chk("t2_b2_data", bus.out_data, body(16'h0202));
        chk("t2_b2_eop",  64'(bus.out_eop), 64'd0);
        chk("t2_b2_yum",  64'(bus.in_yummy), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t2_b3_data", bus.out_data, body(16'h0203));
        chk("t2_b3_sop",  64'(bus.out_sop), 64'd0);
        chk("t2_b3_eop",  64'(bus.out_eop), 64'd1);
        chk("t2_b3_yum",  64'(bus.in_yummy), 64'd1);
        tick();
        chk("t2_end_valid", 64'(bus.out_valid), 64'd0);
        chk("t2_end_yum",   64'(bus.in_yummy), 64'd1);
        chk("t2_end_sop",   64'(bus.out_sop), 64'd1);
        tick();
        chk("t2_yum_off", 64'(bus.in_yummy), 64'd0);

        // 3: fill with out_ready=0, then drain back-to-back
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hdr(8'd0, 16'(16'h0300 + i));
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t3_level_full", 64'(level), 64'd4);
        chk("t3_no_yummy",   64'(bus.in_yummy), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_data", bus.out_data, hdr(8'd0, 16'(16'h0300 + i)));
            tick();
            chk("t3_yummy", 64'(bus.in_yummy), 64'd1);
        end
        chk("t3_level_empty", 64'(level), 64'd0);
        bus.out_ready = 1'b0;
        tick();
        chk("t3_yum_off", 64'(bus.in_yummy), 64'd0);

        // 4: push and pop together while full
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hdr(8'd0, 16'(16'h0400 + i));
            tick();
        end
        bus.in_data   = hdr(8'd0, 16'h0404);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_ovf",   64'(overflow), 64'd0);
        for (int i = 1; i < 5; i++) begin
            chk("t4_data", bus.out_data, hdr(8'd0, 16'(16'h0400 + i)));
            tick();
        end
        chk("t4_level_empty", 64'(level), 64'd0);
        bus.out_ready = 1'b0;
        tick();

        // 5: overflow while full with no pop
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = hdr(8'd0, 16'(16'h0500 + i));
            tick();
        end
        chk("t5_pre_ovf", 64'(overflow), 64'd0);
        bus.in_data = hdr(8'd0, 16'h0504);
        tick();
        bus.in_valid = 1'b0;
        chk("t5_ovf",   64'(overflow), 64'd1);
        chk("t5_level", 64'(level), 64'd4);
        tick();
        chk("t5_ovf_sticky", 64'(overflow), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_data", bus.out_data, hdr(8'd0, 16'(16'h0500 + i)));
            tick();
        end
        chk("t5_level_empty", 64'(level), 64'd0);
        chk("t5_ovf_end",     64'(overflow), 64'd1);
        bus.out_ready = 1'b0;

        // 6: reset mid-packet
        bus.in_valid = 1'b1;
        bus.in_data  = hdr(8'd5, 16'h0600);
        tick();
        for (int i = 1; i < 4; i++) begin
            bus.in_data = body(16'(16'h0600 + i));
            tick();
        end
        bus.in_data   = body(16'h0604);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        chk("t6_level3", 64'(level), 64'd3);
        chk("t6_sop",    64'(bus.out_sop), 64'd0);
        chk("t6_eop",    64'(bus.out_eop), 64'd0);
        chk("t6_data",   bus.out_data, body(16'h0602));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_level", 64'(level), 64'd0);
        chk("t6_rst_yummy", 64'(bus.in_yummy), 64'd0);
        chk("t6_rst_sop",   64'(bus.out_sop), 64'd1);
        chk("t6_rst_ovf",   64'(overflow), 64'd0);
        tick();
        chk("t6_rst_yummy2", 64'(bus.in_yummy), 64'd0);
        #3 rst_n = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = hdr(8'd0, 16'h06AA);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t6_new_valid", 64'(bus.out_valid), 64'd1);
        chk("t6_new_data",  bus.out_data, hdr(8'd0, 16'h06AA));
        chk("t6_new_sop",   64'(bus.out_sop), 64'd1);
        chk("t6_new_eop",   64'(bus.out_eop), 64'd1);
        tick();
        chk("t6_new_yummy", 64'(bus.in_yummy), 64'd1);
        chk("t6_new_level", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
